mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous word memory between the core's instruction-fetch port and its load/store port.
- Each cycle the block grants at most one requester and drives the memory in that same cycle. Read data is routed back to the granted port one cycle later.
- Priority goes to data accesses. A starvation counter bounds how long fetch can wait.
- For stores, the block generates byte lanes and shifts write data into place. Misaligned accesses are rejected with an error response and never reach memory.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is held; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- if_req  in  1  fetch request; address held stable until granted
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request; all d_* inputs held stable until granted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- d_gnt  out  1  data request accepted this cycle (also asserted on error acceptance)
- d_rvalid  out  1  load data valid
- d_rdata  out  32  raw aligned memory word; the core performs extraction
- d_err  out  1  one-cycle misalignment/illegal-size response
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_be  out  4  memory byte enables
- m_addr  out  ADDR_W-2  word address, equal to the granted address [ADDR_W-1:2]
- m_wdata  out  32  lane-shifted store data
- m_rdata  in  32  memory read data, valid the cycle after a read with m_en=1, m_we=0

Behaviour:
- Reset (rst=0 at posedge): starve counter=0, response tag cleared. While rst=0, the combinational outputs if_gnt, d_gnt, m_en, m_we are forced to 0 and m_be is forced to 0000. Registered outputs if_rvalid, d_rvalid, d_err reset to 0. The rdata outputs pass m_rdata through and are don't-care when their rvalid=0.
- Grant (combinational, same cycle):
  - If d_req and (if_req=0 or starve<STARVE_LIMIT), then d_gnt=1.
  - Else if if_req, then if_gnt=1.
  - if_gnt and d_gnt are never both 1.
- Starve counter, updated at posedge:
  - 0 if if_req=0 or if_gnt=1.
  - +1 if d_gnt=1 and if_req=1.
  - Saturates at STARVE_LIMIT.
  - With STARVE_LIMIT=4, fetch is granted on the 5th cycle of contention.
- Alignment check on a data grant: legal if size=00; size=01 and addr[0]=0; size=10 and addr[1:0]=00. Otherwise illegal.
- Illegal data grant:
  - m_en=0.
  - d_err=1 on the next cycle, d_rvalid=0.
  - The counter still counts it as a data grant.
- Legal data grant:
  - m_en=1, m_we=d_we.
  - Loads: m_be=1111.
  - Stores, byte: m_be=0001<<addr[1:0], m_wdata={4{d_wdata[7:0]}}.
  - Stores, half: m_be=0011<<addr[1:0], m_wdata={2{d_wdata[15:0]}}.
  - Stores, word: m_be=1111, m_wdata=d_wdata.
- Fetch grant: m_en=1, m_we=0, m_be=1111, m_addr=if_addr word address.
- Idle cycle (no grant): m_en=0; m_we, m_be, m_wdata driven to 0.
- Response pipeline: a 2-bit tag register records {fetch-read, data-read}.
  - Next cycle: if_rvalid or d_rvalid equals the tag, and the matching rdata equals m_rdata.
  - Stores produce no rvalid.
- Throughput: back-to-back grants every cycle; a new grant may coincide with the previous response.
- Mid-operation reset: an outstanding response is dropped (rvalid=0 after reset), and no memory access occurs while rst=0.

Test Plan:
1. Reset with if_req=1, d_req=1 held → all gnt/m_en=0; after release, d_gnt=1 on the first cycle.
2. Fetch only, if_addr=0x100, m_rdata=0x00000013 next cycle → if_gnt=1, m_addr=0x40, m_be=1111; next cycle if_rvalid=1, if_rdata=0x13.
3. Store byte, d_addr=0x203, d_wdata=0xAB → m_we=1, m_be=1000, m_wdata=0xABABABAB, m_addr=0x80; no d_rvalid follows.
4. Half load at d_addr=0x201 → d_gnt=1, m_en=0, d_err=1 next cycle; size=11 at 0x200 gives the same result.
5. if_req and d_req both held for 6 cycles, STARVE_LIMIT=4 → grant sequence D,D,D,D,F,D; counter back to 0 after the F grant.
6. Alternating D-load/F-fetch back-to-back → each rvalid appears on the correct port exactly one cycle after its grant, never both in the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the fetch/load-store memory arbiter.
// The core/memory side uses master; the arbiter uses slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              m_en;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-3:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  m_en, m_we, m_be, m_addr, m_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output m_en, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and load/store.
// Data has priority; a saturating starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_reg, starve_next;
  logic [1:0]       tag_reg, tag_next;
  logic             err_reg, err_next;

  logic             d_sel, f_sel, d_legal, d_ok;
  logic [3:0]       store_be;
  logic [31:0]      store_wdata;

  always_comb begin
    d_legal = 1'b0;
    case (bus.d_size)
      2'b00:   d_legal = 1'b1;
      2'b01:   d_legal = ~bus.d_addr[0];
      2'b10:   d_legal = (bus.d_addr[1:0] == 2'b00);
      default: d_legal = 1'b0;
    endcase
  end

  // Grants are qualified by rst so nothing reaches memory while in reset.
  assign d_sel = rst & bus.d_req & (~bus.if_req | (starve_reg < LIMIT));
  assign f_sel = rst & bus.if_req & ~d_sel;
  assign d_ok  = d_sel & d_legal;

  always_comb begin
    store_be = 4'b1111;
    case (bus.d_size)
      2'b00:   store_be = 4'b0001 << bus.d_addr[1:0];
      2'b01:   store_be = 4'b0011 << bus.d_addr[1:0];
      default: store_be = 4'b1111;
    endcase
  end

  // Replicate the right-justified store data across every lane it may land in.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (bus.d_size)
          2'b00:   store_wdata[gi*8 +: 8] = bus.d_wdata[7:0];
          2'b01:   store_wdata[gi*8 +: 8] = bus.d_wdata[(gi%2)*8 +: 8];
          default: store_wdata[gi*8 +: 8] = bus.d_wdata[gi*8 +: 8];
        endcase
      end
    end
  endgenerate

  always_comb begin
    bus.if_gnt  = f_sel;
    bus.d_gnt   = d_sel;
    bus.m_en    = d_ok | f_sel;
    bus.m_we    = d_ok & bus.d_we;
    bus.m_be    = 4'b0000;
    bus.m_addr  = d_sel ? bus.d_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
    bus.m_wdata = 32'h0;
    if (f_sel || (d_ok && !bus.d_we)) begin
      bus.m_be = 4'b1111;
    end else if (d_ok) begin
      bus.m_be    = store_be;
      bus.m_wdata = store_wdata;
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if (!bus.if_req || f_sel) begin
      starve_next = '0;
    end else if (d_sel && (starve_reg < LIMIT)) begin
      starve_next = starve_reg + 1'b1;
    end
    tag_next = {f_sel, d_ok & ~bus.d_we};
    err_next = d_sel & ~d_legal;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_reg <= '0;
      tag_reg    <= 2'b00;
      err_reg    <= 1'b0;
    end else begin
      starve_reg <= starve_next;
      tag_reg    <= tag_next;
      err_reg    <= err_next;
    end
  end

  assign bus.if_rvalid = tag_reg[1];
  assign bus.d_rvalid  = tag_reg[0];
  assign bus.d_err     = err_reg;
  assign bus.if_rdata  = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a reference model of the grant rules and
// memory contents is compared against the DUT every cycle, plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] tb_mem    [1024];
  logic [31:0] model_mem [1024];

  // Reference model state: consecutive data wins while fetch waits, pending responses.
  int          waited;
  bit          p_if, p_d, p_err;
  logic [31:0] p_if_data, p_d_data;

  bit          e_d, e_f, e_lg, e_en, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_wdata;

  bit          cap_en, cap_we;
  logic [3:0]  cap_be;
  logic [29:0] cap_addr;
  logic [31:0] cap_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic bit legal_of(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a == 2'd0);
  endfunction

  task automatic step_neg();
    @(negedge clk);
    e_d   = rst && bus.d_req && (!bus.if_req || waited < LIMIT);
    e_f   = rst && bus.if_req && !e_d;
    e_lg  = legal_of(bus.d_size, bus.d_addr[1:0]);
    e_en  = e_f || (e_d && e_lg);
    e_we  = e_d && e_lg && bus.d_we;
    e_be  = 4'h0;
    e_wdata = 32'h0;
    if (e_en && !e_we) e_be = 4'hF;
    if (e_we) begin
      case (bus.d_size)
        2'd0: begin e_be = 4'(1 << bus.d_addr[1:0]); e_wdata = 32'(bus.d_wdata[7:0]) * 32'h01010101; end
        2'd1: begin e_be = 4'(3 << bus.d_addr[1:0]); e_wdata = 32'(bus.d_wdata[15:0]) * 32'h00010001; end
        default: begin e_be = 4'hF; e_wdata = bus.d_wdata; end
      endcase
    end
    chk("if_gnt", bus.if_gnt, e_f);
    chk("d_gnt", bus.d_gnt, e_d);
    chk("m_en", bus.m_en, e_en);
    if (e_en || !e_d) begin
      chk("m_we", bus.m_we, e_we);
      chk("m_be", bus.m_be, e_be);
    end
    if (e_en) chk("m_addr", bus.m_addr, e_f ? bus.if_addr[31:2] : bus.d_addr[31:2]);
    if (e_we || !(e_d || e_f)) chk("m_wdata", bus.m_wdata, e_wdata);
    chk("if_rvalid", bus.if_rvalid, p_if);
    chk("d_rvalid", bus.d_rvalid, p_d);
    chk("d_err", bus.d_err, p_err);
    chk("rvalid_exclusive", bus.if_rvalid && bus.d_rvalid, 0);
    if (p_if) chk("if_rdata", bus.if_rdata, p_if_data);
    if (p_d)  chk("d_rdata", bus.d_rdata, p_d_data);
    cap_en = bus.m_en; cap_we = bus.m_we; cap_be = bus.m_be;
    cap_addr = bus.m_addr; cap_wdata = bus.m_wdata;
  endtask

  task automatic step_pos();
    bit rd;
    @(posedge clk);
    if (!rst) begin
      waited = 0; p_if = 0; p_d = 0; p_err = 0;
    end else begin
      p_if      = e_f;
      p_if_data = model_mem[bus.if_addr[11:2]];
      p_d       = e_d && e_lg && !bus.d_we;
      p_d_data  = model_mem[bus.d_addr[11:2]];
      p_err     = e_d && !e_lg;
      if (e_we)
        for (int b = 0; b < 4; b++)
          if (e_be[b]) model_mem[bus.d_addr[11:2]][b*8 +: 8] = e_wdata[b*8 +: 8];
      if (!bus.if_req || e_f) waited = 0;
      else if (e_d && waited < LIMIT) waited++;
    end
    // Memory stand-in responds to what the DUT actually drove.
    if (cap_en && cap_we)
      for (int b = 0; b < 4; b++)
        if (cap_be[b]) tb_mem[cap_addr[9:0]][b*8 +: 8] = cap_wdata[b*8 +: 8];
    rd = cap_en && !cap_we;
    #1;
    bus.m_rdata = rd ? tb_mem[cap_addr[9:0]] : $urandom();
  endtask

  task automatic new_d();
    int r;
    bus.d_req   = ($urandom_range(0, 3) != 0);
    bus.d_we    = $urandom_range(0, 1) == 1;
    r = $urandom_range(0, 9);
    bus.d_size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
    bus.d_addr  = 32'($urandom_range(0, 4095));
    if ($urandom_range(0, 3) != 0) begin
      if (bus.d_size == 2'd1) bus.d_addr[0] = 1'b0;
      if (bus.d_size == 2'd2) bus.d_addr[1:0] = 2'b00;
    end
    bus.d_wdata = $urandom();
  endtask

  bit seq_d [6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i] = $urandom();
      model_mem[i] = tb_mem[i];
    end
    waited = 0; p_if = 0; p_d = 0; p_err = 0;
    p_if_data = 0; p_d_data = 0;
    rst = 1'b0;
    bus.m_rdata = 32'h0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h10; bus.d_wdata = 32'h0;

    // Reset with both requesters asserted.
    repeat (2) begin
      step_neg();
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_m_en", bus.m_en, 0);
      chk("rst_m_be", bus.m_be, 0);
      step_pos();
    end
    rst = 1'b1;

    // Contention from reset release: D,D,D,D,F,D.
    for (int i = 0; i < 6; i++) begin
      step_neg();
      chk("contend_d_gnt", bus.d_gnt, seq_d[i]);
      chk("contend_if_gnt", bus.if_gnt, !seq_d[i]);
      step_pos();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    step_neg(); step_pos();

    // Fetch only.
    tb_mem[10'h40] = 32'h13; model_mem[10'h40] = 32'h13;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step_neg();
    chk("fetch_gnt", bus.if_gnt, 1);
    chk("fetch_m_addr", bus.m_addr, 32'h40);
    chk("fetch_m_be", bus.m_be, 4'hF);
    step_pos();
    bus.if_req = 1'b0;
    step_neg();
    chk("fetch_rvalid", bus.if_rvalid, 1);
    chk("fetch_rdata", bus.if_rdata, 32'h13);
    step_pos();

    // Byte store to the top lane.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd0; bus.d_addr = 32'h203; bus.d_wdata = 32'hAB;
    step_neg();
    chk("store_m_we", bus.m_we, 1);
    chk("store_m_be", bus.m_be, 4'b1000);
    chk("store_m_wdata", bus.m_wdata, 32'hABABABAB);
    chk("store_m_addr", bus.m_addr, 32'h80);
    step_pos();
    bus.d_req = 1'b0;
    step_neg();
    chk("store_no_rvalid", bus.d_rvalid, 0);
    step_pos();

    // Misaligned half load, then illegal size.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd1; bus.d_addr = 32'h201;
    step_neg();
    chk("mis_half_gnt", bus.d_gnt, 1);
    chk("mis_half_m_en", bus.m_en, 0);
    step_pos();
    bus.d_size = 2'd3; bus.d_addr = 32'h200;
    step_neg();
    chk("mis_half_err", bus.d_err, 1);
    chk("mis_half_rvalid", bus.d_rvalid, 0);
    chk("size3_gnt", bus.d_gnt, 1);
    chk("size3_m_en", bus.m_en, 0);
    step_pos();
    bus.d_req = 1'b0;
    step_neg();
    chk("size3_err", bus.d_err, 1);
    step_pos();

    // Randomized traffic with occasional mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      bit d_done, f_done;
      step_neg();
      d_done = e_d;
      f_done = e_f;
      step_pos();
      rst = ($urandom_range(0, 49) != 0);
      if (!bus.d_req || d_done) new_d();
      if (!bus.if_req || f_done) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = 32'($urandom_range(0, 4095));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
